touch_panel_adc_responder: RTL and testbench

//  SPI responder emulating an ADS7843-class resistive touch-screen ADC, the far end of the

---
 rtl/touch_panel_adc_responder.sv | 170 +++++++++++++++++
 tb/tb_touch_panel_adc_responder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/touch_panel_adc_responder.sv
// SPI responder that behaves like an ADS7843-class touch-screen ADC, clocked from clk_clk.
// Build option: define TP_AUX_CH_EN to add aux_in, which is returned for channel codes 010 and 110.
module touch_panel_adc_responder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DATA_BITS   = 12
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset_n,
    input  logic                 tp_sclk,
    input  logic                 tp_mosi,
    input  logic                 tp_ss_n,
    output logic                 tp_miso,
    output logic                 tp_busy,
    output logic                 tp_pen_irq_n,
    input  logic [DATA_BITS-1:0] touch_x,
    input  logic [DATA_BITS-1:0] touch_y,
`ifdef TP_AUX_CH_EN
    input  logic [DATA_BITS-1:0] aux_in,
`endif
    input  logic                 pen_down
);

    localparam int unsigned      CNT_W    = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] CMD_LAST = CNT_W'(7);
    localparam logic [CNT_W-1:0] REM_BYTE = CNT_W'(7);
    localparam logic [CNT_W-1:0] REM_FULL = CNT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HUNT,
        S_CMD,
        S_BUSY,
        S_DATA
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] ss_sync;
    logic                   sclk_d;
    logic                   sclk_s;
    logic                   mosi_s;
    logic                   ss_s;
    logic                   rise_c;
    logic                   fall_c;

    state_t                 state;
    logic [5:0]             cmd_sr;
    logic [CNT_W-1:0]       bit_cnt;
    logic [DATA_BITS-1:0]   data_sr;
    logic                   mode8;
    logic [1:0]             pd_mode;
    logic [DATA_BITS-1:0]   sample_c;

    // Host signal synchronizers plus one stage of SCLK history for edge detection
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            ss_sync   <= '1;
            sclk_d    <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], tp_sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], tp_mosi};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], tp_ss_n};
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];
    assign ss_s   = ss_sync[SYNC_STAGES-1];
    assign rise_c = sclk_s & ~sclk_d;
    assign fall_c = ~sclk_s & sclk_d;

    // cmd_sr holds command bits 6..1 while the 8th bit arrives, so A2..A0 sit in [5:3]
    always_comb begin
        sample_c = '0;
        case (cmd_sr[5:3])
            3'b101:  sample_c = touch_x;
            3'b001:  sample_c = touch_y;
`ifdef TP_AUX_CH_EN
            3'b010,
            3'b110:  sample_c = aux_in;
`endif
            default: sample_c = '0;
        endcase
    end

    // Frame FSM; deasserted chip select overrides everything except the latched pd_mode
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state   <= S_IDLE;
            cmd_sr  <= '0;
            bit_cnt <= '0;
            data_sr <= '0;
            mode8   <= 1'b0;
            pd_mode <= 2'b00;
            tp_miso <= 1'b0;
            tp_busy <= 1'b0;
        end else if (ss_s) begin
            state   <= S_IDLE;
            cmd_sr  <= '0;
            bit_cnt <= '0;
            tp_miso <= 1'b0;
            tp_busy <= 1'b0;
        end else begin
            case (state)
                S_IDLE: state <= S_HUNT;
                S_HUNT: begin
                    if (rise_c && mosi_s) begin
                        state   <= S_CMD;
                        cmd_sr  <= '0;
                        bit_cnt <= CNT_W'(1);
                    end
                end
                S_CMD: begin
                    if (rise_c) begin
                        if (bit_cnt == CMD_LAST) begin
                            mode8   <= cmd_sr[2];
                            pd_mode <= {cmd_sr[0], mosi_s};
                            data_sr <= sample_c;
                            bit_cnt <= '0;
                            state   <= S_BUSY;
                        end else begin
                            cmd_sr  <= {cmd_sr[4:0], mosi_s};
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                S_BUSY: begin
                    // First falling edge raises busy, the second one presents the MSB
                    if (fall_c) begin
                        if (!tp_busy) begin
                            tp_busy <= 1'b1;
                        end else begin
                            tp_busy <= 1'b0;
                            tp_miso <= data_sr[DATA_BITS-1];
                            data_sr <= {data_sr[DATA_BITS-2:0], 1'b0};
                            bit_cnt <= mode8 ? REM_BYTE : REM_FULL;
                            state   <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (fall_c) begin
                        if (bit_cnt == '0) begin
                            tp_miso <= 1'b0;
                            state   <= S_HUNT;
                        end else begin
                            tp_miso <= data_sr[DATA_BITS-1];
                            data_sr <= {data_sr[DATA_BITS-2:0], 1'b0};
                            bit_cnt <= bit_cnt - CNT_W'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Pen interrupt is only armed in power-down mode 00
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            tp_pen_irq_n <= 1'b1;
        end else begin
            tp_pen_irq_n <= (pd_mode == 2'b00) ? ~pen_down : 1'b1;
        end
    end

endmodule

// File: tb/tb_touch_panel_adc_responder.sv
// Scoreboard bench for touch_panel_adc_responder: expected MISO/busy per SCLK rise are queued
// when a command is scheduled and popped as the emulated master clocks the frame.
module tb_touch_panel_adc_responder;

    localparam int unsigned DB   = 12;
    localparam int          HALF = 50;

    logic          clk_clk = 1'b0;
    logic          reset_reset_n;
    logic          tp_sclk;
    logic          tp_mosi;
    logic          tp_ss_n;
    logic          tp_miso;
    logic          tp_busy;
    logic          tp_pen_irq_n;
    logic [DB-1:0] touch_x;
    logic [DB-1:0] touch_y;
    logic          pen_down;
`ifdef TP_AUX_CH_EN
    logic [DB-1:0] aux_in;
`endif

    int   n_checks = 0;
    int   n_errors = 0;
    logic mosi_q[$];
    logic exp_miso_q[$];
    logic exp_busy_q[$];

    touch_panel_adc_responder #(
        .SYNC_STAGES(2),
        .DATA_BITS  (DB)
    ) dut (
        .clk_clk      (clk_clk),
        .reset_reset_n(reset_reset_n),
        .tp_sclk      (tp_sclk),
        .tp_mosi      (tp_mosi),
        .tp_ss_n      (tp_ss_n),
        .tp_miso      (tp_miso),
        .tp_busy      (tp_busy),
        .tp_pen_irq_n (tp_pen_irq_n),
        .touch_x      (touch_x),
        .touch_y      (touch_y),
`ifdef TP_AUX_CH_EN
        .aux_in       (aux_in),
`endif
        .pen_down     (pen_down)
    );

    always #5 clk_clk = ~clk_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic add_zero_byte();
        for (int i = 0; i < 8; i++) begin
            mosi_q.push_back(1'b0);
            exp_miso_q.push_back(1'b0);
            exp_busy_q.push_back(1'b0);
        end
    endtask

    // Command byte plus 16 trailing clocks; the rise after the 8th command bit sees busy,
    // the next nbits rises see the sample MSB first, the rest see zero
    task automatic add_cmd(input logic [7:0] cmd, input logic [DB-1:0] sample, input int nbits);
        for (int i = 7; i >= 0; i--) begin
            mosi_q.push_back(cmd[i]);
            exp_miso_q.push_back(1'b0);
            exp_busy_q.push_back(1'b0);
        end
        for (int j = 0; j < 16; j++) begin
            mosi_q.push_back(1'b0);
            exp_busy_q.push_back(j == 0);
            if (j >= 1 && j <= nbits) exp_miso_q.push_back(sample[DB-j]);
            else                      exp_miso_q.push_back(1'b0);
        end
    endtask

    // Clock out the queued MOSI bits; abort_after >= 0 stops early, chg_at flips the samples
    task automatic run_frame(input int abort_after, input int chg_at);
        int   idx;
        logic em;
        logic eb;
        idx = 0;
        tp_ss_n = 1'b0;
        #(2*HALF);
        while (mosi_q.size() > 0) begin
            if (abort_after >= 0 && idx == abort_after) break;
            tp_mosi = mosi_q.pop_front();
            #HALF;
            tp_sclk = 1'b1;
            idx++;
            em = exp_miso_q.pop_front();
            eb = exp_busy_q.pop_front();
            check($sformatf("miso_r%0d", idx), 16'(tp_miso), 16'(em));
            check($sformatf("busy_r%0d", idx), 16'(tp_busy), 16'(eb));
            if (idx == chg_at) begin
                touch_x = ~touch_x;
                touch_y = ~touch_y;
            end
            #HALF;
            tp_sclk = 1'b0;
        end
        mosi_q.delete();
        exp_miso_q.delete();
        exp_busy_q.delete();
        #HALF;
        tp_ss_n = 1'b1;
        tp_mosi = 1'b0;
    endtask

    task automatic gap();
        #(2*HALF);
    endtask

    initial begin
        reset_reset_n = 1'b0;
        tp_sclk  = 1'b0;
        tp_mosi  = 1'b0;
        tp_ss_n  = 1'b1;
        pen_down = 1'b1;
        touch_x  = '0;
        touch_y  = '0;
`ifdef TP_AUX_CH_EN
        aux_in   = '0;
`endif
        repeat (3) @(posedge clk_clk);
        #1;
        check("rst_miso", 16'(tp_miso), 16'd0);
        check("rst_busy", 16'(tp_busy), 16'd0);
        check("rst_irq", 16'(tp_pen_irq_n), 16'd1);
        @(negedge clk_clk);
        reset_reset_n = 1'b1;
        repeat (2) @(posedge clk_clk);
        #1;
        check("irq_after_rst", 16'(tp_pen_irq_n), 16'd0);
        check("idle_miso", 16'(tp_miso), 16'd0);

        // X, 12-bit, sample changes mid-data
        touch_x = 12'hABC;
        add_cmd(8'hD0, 12'hABC, 12);
        run_frame(-1, 13);
        gap();

        // Y, 8-bit
        touch_y = 12'h5A3;
        add_cmd(8'h98, 12'h5A3, 8);
        run_frame(-1, -1);
        gap();

        // Leading zero byte is ignored
        touch_y = 12'h123;
        add_zero_byte();
        add_cmd(8'h90, 12'h123, 12);
        run_frame(-1, -1);
        gap();

        // Two commands in one frame
        touch_x = 12'h3C5;
        touch_y = 12'hA5A;
        add_cmd(8'hD0, 12'h3C5, 12);
        add_cmd(8'h90, 12'hA5A, 12);
        run_frame(-1, -1);
        gap();

        // Abort after 5 data bits, then abort while busy
        touch_x = 12'hFFF;
        add_cmd(8'hD0, 12'hFFF, 12);
        run_frame(14, -1);
        repeat (4) @(posedge clk_clk);
        #1;
        check("abort_data_miso", 16'(tp_miso), 16'd0);
        check("abort_data_busy", 16'(tp_busy), 16'd0);
        gap();
        add_cmd(8'hD0, 12'hFFF, 12);
        run_frame(8, -1);
        repeat (4) @(posedge clk_clk);
        #1;
        check("abort_busy_busy", 16'(tp_busy), 16'd0);
        check("abort_busy_miso", 16'(tp_miso), 16'd0);
        gap();
        touch_y = 12'h6E1;
        add_cmd(8'h90, 12'h6E1, 12);
        run_frame(-1, -1);
        gap();

        // Power-down mode gating of the pen interrupt
        pen_down = 1'b1;
        touch_y  = 12'h0F0;
        add_cmd(8'h93, 12'h0F0, 12);
        run_frame(-1, -1);
        repeat (2) @(posedge clk_clk);
        #1;
        check("irq_pd11", 16'(tp_pen_irq_n), 16'd1);
        add_cmd(8'h90, 12'h0F0, 12);
        run_frame(-1, -1);
        repeat (2) @(posedge clk_clk);
        #1;
        check("irq_pd00_down", 16'(tp_pen_irq_n), 16'd0);
        pen_down = 1'b0;
        repeat (2) @(posedge clk_clk);
        #1;
        check("irq_pd00_up", 16'(tp_pen_irq_n), 16'd1);
        gap();

        // Unmapped and auxiliary channel codes
        touch_x = 12'hFFF;
        touch_y = 12'hFFF;
        add_cmd(8'h80, 12'h000, 12);
        run_frame(-1, -1);
        gap();
`ifdef TP_AUX_CH_EN
        aux_in = 12'h7FF;
        add_cmd(8'hA0, 12'h7FF, 12);
        add_cmd(8'hE8, 12'h7FF, 8);
`else
        add_cmd(8'hA0, 12'h000, 12);
        add_cmd(8'hE8, 12'h000, 8);
`endif
        run_frame(-1, -1);
        gap();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
